run_monitor: RTL

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/run_pkg.sv | 18 +
 rtl/run_monitor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/run_pkg.sv
// Shared types and constants for the run monitor.
// Contents: the FSM state encoding (run_state_e), the CPU cycle counter width
// (CNT_W) and the width of the CPU-reset hold counter (RST_CNT_W).
package run_pkg;

  localparam int unsigned CNT_W     = 24;
  localparam int unsigned RST_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_FETCH = 3'd3,
    ST_DUMP  = 3'd4,
    ST_DONE  = 3'd5
  } run_state_e;

endpackage : run_pkg

// File: rtl/run_monitor.sv
// Run monitor: resets a CPU under test, lets it run for a bounded number of
// cycles (or until halted), then freezes it and streams its register file out
// over a valid/ready dump interface.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   start_i, halt_i            launch a run / stop the run early
//   cpu_rst_n_o, cpu_en_o      CPU reset (active low) and advance enable
//   cycle_cnt_o                CPU cycles completed in the current/last run
//   rf_addr_o, rf_data_i       register-file read port (combinational data)
//   dump_valid_o, dump_ready_i dump stream handshake
//   dump_idx_o, dump_data_o    dumped register index and value
//   busy_o, done_o             run in progress / dump complete
module run_monitor
  import run_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned END_COUNT  = 100,
  parameter int unsigned RST_CYCLES = 1,
  localparam int unsigned ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              halt_i,
  output logic              cpu_rst_n_o,
  output logic              cpu_en_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(END_COUNT - 1);
  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0]    IDX_LAST = ADDR_W'(NUM_REGS - 1);

  run_state_e           state_q,      state_d;
  logic [RST_CNT_W-1:0] rst_cnt_q,    rst_cnt_d;
  logic [CNT_W-1:0]     cycle_cnt_q,  cycle_cnt_d;
  logic [ADDR_W-1:0]    idx_q,        idx_d;
  logic [ADDR_W-1:0]    dump_idx_q,   dump_idx_d;
  logic [DATA_W-1:0]    dump_data_q,  dump_data_d;
  logic                 cpu_rst_n_q,  cpu_rst_n_d;
  logic                 cpu_en_q,     cpu_en_d;
  logic                 dump_valid_q, dump_valid_d;
  logic                 busy_q,       busy_d;
  logic                 done_q,       done_d;

  // Next-state, counters and output decode. Status outputs are decoded from
  // the next state so the registered copies line up with the state register.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    idx_d        = idx_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    cpu_rst_n_d  = 1'b0;
    cpu_en_d     = 1'b0;
    dump_valid_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_RESET;
          rst_cnt_d   = '0;
          cycle_cnt_d = '0;
          idx_d       = '0;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
        end
      end
      ST_RUN: begin
        // Every RUN cycle is counted, including the one that sees halt_i.
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if ((cycle_cnt_q == CNT_LAST) || halt_i) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        dump_data_d = rf_data_i;
        dump_idx_d  = idx_q;
        state_d     = ST_DUMP;
      end
      ST_DUMP: begin
        if (dump_ready_i) begin
          // Index only advances below the last register, so it never wraps.
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cpu_rst_n_d  = (state_d != ST_IDLE) && (state_d != ST_RESET);
    cpu_en_d     = (state_d == ST_RUN);
    dump_valid_d = (state_d == ST_DUMP);
    busy_d       = (state_d == ST_RESET) || (state_d == ST_RUN) ||
                   (state_d == ST_FETCH) || (state_d == ST_DUMP);
    done_d       = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      cycle_cnt_q  <= '0;
      idx_q        <= '0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
      cpu_rst_n_q  <= 1'b0;
      cpu_en_q     <= 1'b0;
      dump_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      idx_q        <= idx_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      cpu_en_q     <= cpu_en_d;
      dump_valid_q <= dump_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign cpu_en_o     = cpu_en_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign rf_addr_o    = idx_q;
  assign dump_valid_o = dump_valid_q;
  assign dump_idx_o   = dump_idx_q;
  assign dump_data_o  = dump_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule : run_monitor
